// File: rtl/score_pkg.sv
// score_pkg: shared types, widths and BCD helpers for the score keeper.
// Contents: state_e (RUN/LOCK/FULL), bcd_t digit pair, SCORE_W/TENS_W/ONES_W,
// DEF_MAX_SCORE, bcd_inc/bcd_dec incremental digit update functions.
package score_pkg;

    localparam int unsigned SCORE_W       = 5;
    localparam int unsigned TENS_W        = 2;
    localparam int unsigned ONES_W        = 4;
    localparam int unsigned DEF_MAX_SCORE = 30;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOCK,
        ST_FULL
    } state_e;

    typedef struct packed {
        logic [TENS_W-1:0] tens;
        logic [ONES_W-1:0] ones;
    } bcd_t;

    // Add one to a BCD pair, carrying 9 -> 0 into tens.
    function automatic bcd_t bcd_inc(input bcd_t b);
        bcd_t r;
        r = b;
        if (b.ones == ONES_W'(9)) begin
            r.ones = '0;
            r.tens = b.tens + TENS_W'(1);
        end else begin
            r.ones = b.ones + ONES_W'(1);
        end
        return r;
    endfunction

    // Subtract one from a BCD pair, borrowing 0 -> 9 from tens.
    function automatic bcd_t bcd_dec(input bcd_t b);
        bcd_t r;
        r = b;
        if (b.ones == '0) begin
            r.ones = ONES_W'(9);
            r.tens = b.tens - TENS_W'(1);
        end else begin
            r.ones = b.ones - ONES_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/score_keeper_sync_rise.sv
// sync_rise: 2-flop synchronizer plus rising-edge detector for one async level.
// Ports: clock, reset (async, active-high), din (async level),
//        level (synchronized level), rise (one-cycle pulse on synchronized rise).
module sync_rise (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic       s1_q;
    logic       s2_q;
    logic       hist_q;
    logic [2:0] prime_q;

    // Synchronizer, edge history, and a prime shifter that fills with ones
    // once the history holds a post-reset sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            hist_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            s1_q    <= din;
            s2_q    <= s1_q;
            hist_q  <= s2_q;
            prime_q <= {prime_q[1:0], 1'b1};
        end
    end

    assign level = s2_q;
    // Gated by prime so a level already high at reset release is not an edge.
    assign rise  = s2_q & ~hist_q & prime_q[2];

endmodule

// File: rtl/score_keeper.sv
// score_keeper: saturating 0..MAX_SCORE score with binary and BCD outputs.
// Ports: clock, reset (async, active-high), hit/miss/clear (async levels),
//        score (binary), tens/ones (BCD digits), full (score at ceiling),
//        changed (one-cycle pulse after score changes).
// Build option: SCORE_PENALTY_EN enables the miss/decrement path.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE      = DEF_MAX_SCORE,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hit,
    input  logic               miss,
    input  logic               clear,
    output logic [SCORE_W-1:0] score,
    output logic [TENS_W-1:0]  tens,
    output logic [ONES_W-1:0]  ones,
    output logic               full,
    output logic               changed
);

    localparam int unsigned        CNT_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MAX_S    = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] MAX_M1   = SCORE_W'(MAX_SCORE - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] score_q, score_d;
    bcd_t               bcd_q, bcd_d;
    logic               full_q, full_d;
    logic               changed_q, changed_d;

    logic hit_rise, hit_ev, miss_ev, clr_level;
    logic unused_hit_level, unused_clr_rise;

    sync_rise u_hit (
        .clock (clock),
        .reset (reset),
        .din   (hit),
        .level (unused_hit_level),
        .rise  (hit_rise)
    );

    sync_rise u_clr (
        .clock (clock),
        .reset (reset),
        .din   (clear),
        .level (clr_level),
        .rise  (unused_clr_rise)
    );

`ifdef SCORE_PENALTY_EN
    logic miss_rise, unused_miss_level;

    sync_rise u_miss (
        .clock (clock),
        .reset (reset),
        .din   (miss),
        .level (unused_miss_level),
        .rise  (miss_rise)
    );

    // Simultaneous hit and miss cancel out.
    assign hit_ev  = hit_rise & ~miss_rise;
    assign miss_ev = miss_rise & ~hit_rise;
`else
    logic unused_miss;
    assign unused_miss = miss;
    assign hit_ev      = hit_rise;
    assign miss_ev     = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            score_q   <= '0;
            bcd_q     <= '0;
            full_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            bcd_q     <= bcd_d;
            full_q    <= full_d;
            changed_q <= changed_d;
        end
    end

    // Next-state, score and BCD update; clear overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        bcd_d   = bcd_q;

        if (clr_level) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            score_d = '0;
            bcd_d   = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hit_ev && score_q != MAX_S) begin
                        score_d = score_q + SCORE_W'(1);
                        bcd_d   = bcd_inc(bcd_q);
                        if (score_q >= MAX_M1) begin
                            state_d = ST_FULL;
                        end else begin
                            cnt_d   = CNT_LOAD;
                            state_d = ST_LOCK;
                        end
                    end else if (miss_ev && score_q != '0) begin
                        score_d = score_q - SCORE_W'(1);
                        bcd_d   = bcd_dec(bcd_q);
                        cnt_d   = CNT_LOAD;
                        state_d = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (cnt_q == '0) begin
                        state_d = (score_q == MAX_S) ? ST_FULL : ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_FULL: begin
                    if (miss_ev) begin
                        score_d = score_q - SCORE_W'(1);
                        bcd_d   = bcd_dec(bcd_q);
                        cnt_d   = CNT_LOAD;
                        state_d = ST_LOCK;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        full_d    = (score_d == MAX_S);
        changed_d = (score_d != score_q);
    end

    assign score   = score_q;
    assign tens    = bcd_q.tens;
    assign ones    = bcd_q.ones;
    assign full    = full_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper (MAX_SCORE=30, LOCKOUT_CYCLES=4).
// Expectations follow SCORE_PENALTY_EN when the bench is built with it.
module tb_score_keeper;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       hit   = 1'b0;
    logic       miss  = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] score;
    logic [1:0] tens;
    logic [3:0] ones;
    logic       full;
    logic       changed;

    typedef struct packed {
        logic [4:0] s;
        logic [1:0] t;
        logic [3:0] o;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    score_keeper #(
        .MAX_SCORE      (30),
        .LOCKOUT_CYCLES (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .hit     (hit),
        .miss    (miss),
        .clear   (clear),
        .score   (score),
        .tens    (tens),
        .ones    (ones),
        .full    (full),
        .changed (changed)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input int s);
        exp_t e;
        e.s = 5'(s);
        e.t = 2'(s / 10);
        e.o = 4'(s % 10);
        e.f = (s == 30);
        return e;
    endfunction

    // Monitor: every changed pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (!reset && changed) begin
            exp_t act;
            exp_t e;
            act = {score, tens, ones, full};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_changed: got score=%0d tens=%0d ones=%0d full=%0d, expected no change",
                         score, tens, ones, full);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL changed_value: got s=%0d t=%0d o=%0d f=%0d expected s=%0d t=%0d o=%0d f=%0d",
                             act.s, act.t, act.o, act.f, e.s, e.t, e.o, e.f);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Quiet-state check: all expected pulses consumed, outputs match s.
    task automatic settle(input string nm, input int s);
        chk({nm, " pending"}, exp_q.size(), 0);
        exp_q.delete();
        chk({nm, " score"},   int'(score),   s);
        chk({nm, " tens"},    int'(tens),    s / 10);
        chk({nm, " ones"},    int'(ones),    s % 10);
        chk({nm, " full"},    int'(full),    (s == 30) ? 1 : 0);
        chk({nm, " changed"}, int'(changed), 0);
    endtask

    task automatic hit_once(input bit ch, input int s);
        if (ch) exp_q.push_back(mk(s));
        hit = 1'b1;
        cyc(2);
        hit = 1'b0;
        cyc(8);
        settle("hit", s);
    endtask

    task automatic miss_once(input bit ch, input int s);
        if (ch) exp_q.push_back(mk(s));
        miss = 1'b1;
        cyc(2);
        miss = 1'b0;
        cyc(8);
        settle("miss", s);
    endtask

    initial begin
        // Reset values.
        cyc(3);
        chk("rst score",   int'(score),   0);
        chk("rst tens",    int'(tens),    0);
        chk("rst ones",    int'(ones),    0);
        chk("rst full",    int'(full),    0);
        chk("rst changed", int'(changed), 0);
        reset = 1'b0;
        cyc(5);

        // Single hit latency: hit sampled high at edge k.
        exp_q.push_back(mk(1));
        hit = 1'b1;
        cyc(2);
        chk("lat k+1 score", int'(score), 0);
        cyc(1);
        chk("lat k+2 score",   int'(score),   1);
        chk("lat k+2 changed", int'(changed), 1);
        cyc(1);
        chk("lat k+3 changed", int'(changed), 0);
        hit = 1'b0;
        cyc(8);
        settle("single", 1);

        // Lockout: rises at k, k+3 (discarded), k+8 (accepted).
        exp_q.push_back(mk(2));
        hit = 1'b1; cyc(2);
        hit = 1'b0; cyc(1);
        hit = 1'b1; cyc(2);
        hit = 1'b0; cyc(3);
        chk("lockout mid score", int'(score), 2);
        exp_q.push_back(mk(3));
        hit = 1'b1; cyc(2);
        hit = 1'b0; cyc(8);
        settle("lockout", 3);

        // Reset mid-LOCK with hit held high.
        exp_q.push_back(mk(4));
        hit = 1'b1;
        cyc(3);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst score",   int'(score),   0);
        chk("midrst tens",    int'(tens),    0);
        chk("midrst ones",    int'(ones),    0);
        chk("midrst full",    int'(full),    0);
        chk("midrst changed", int'(changed), 0);
        cyc(2);
        reset = 1'b0;
        cyc(10);
        settle("held", 0);
        hit = 1'b0;
        cyc(3);
        hit_once(1'b1, 1);

        // Climb to 9, carry into 10, climb to 30 and saturate.
        for (int s = 2; s <= 9; s++) hit_once(1'b1, s);
        hit_once(1'b1, 10);
        for (int s = 11; s <= 29; s++) hit_once(1'b1, s);
        hit_once(1'b1, 30);
        hit_once(1'b0, 30);
        hit_once(1'b0, 30);

`ifdef SCORE_PENALTY_EN
        miss_once(1'b1, 29);
        hit_once(1'b1, 30);
`else
        miss_once(1'b0, 30);
`endif

        // Clear from 30: one changed pulse to zero.
        exp_q.push_back(mk(0));
        clear = 1'b1;
        cyc(5);
        clear = 1'b0;
        cyc(4);
        settle("clear", 0);

        miss_once(1'b0, 0);
        for (int s = 1; s <= 5; s++) hit_once(1'b1, s);
`ifdef SCORE_PENALTY_EN
        miss_once(1'b1, 4);
        hit_once(1'b1, 5);
`else
        miss_once(1'b0, 5);
`endif

        // Simultaneous hit+miss at 5, then a hit 3 cycles later.
        exp_q.push_back(mk(6));
        hit = 1'b1; miss = 1'b1; cyc(2);
        hit = 1'b0; miss = 1'b0; cyc(1);
        hit = 1'b1; cyc(2);
        hit = 1'b0; cyc(8);
        settle("both", 6);

`ifdef SCORE_PENALTY_EN
        for (int s = 7; s <= 10; s++) hit_once(1'b1, s);
        miss_once(1'b1, 9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
